// File: rtl/line_buffer_feeder.sv
// Line-buffer feeder: shifts one line of filtered samples into a tapped
// line buffer, zero-pads short lines and holds the line until acknowledged.
`ifndef kNoOfPartitions
`define kNoOfPartitions 4
`endif
`ifndef kPartitionSize
`define kPartitionSize 3
`endif
`ifndef kFilteredDataLength
`define kFilteredDataLength 8
`endif

module line_buffer_feeder #(
    parameter int pNoTaps     = `kNoOfPartitions,
    parameter int pTapsWidth  = `kPartitionSize,
    parameter int pDataLength = `kFilteredDataLength,
    parameter int pCountWidth = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [pDataLength-1:0] in_data,
    input  logic                   in_last,
    output logic                   lb_enable,
    output logic [pDataLength-1:0] lb_shift_in,
    output logic                   line_valid,
    input  logic                   line_ack,
    output logic [pCountWidth-1:0] fill_count
);

    localparam int D = (pNoTaps - 1) * pTapsWidth + 1;
    localparam logic [pCountWidth-1:0] kDepth = pCountWidth'(D);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PAD,
        S_SETTLE,
        S_HOLD
    } state_e;

    state_e                 state_q, state_d;
    logic [pCountWidth-1:0] fill_count_q, fill_count_d;
    logic [pCountWidth-1:0] count_inc;
    logic                   lb_enable_q, lb_enable_d;
    logic [pDataLength-1:0] lb_shift_in_q, lb_shift_in_d;
    logic                   accept;

    assign in_ready    = (state_q == S_FILL);
    assign line_valid  = (state_q == S_HOLD);
    assign lb_enable   = lb_enable_q;
    assign lb_shift_in = lb_shift_in_q;
    assign fill_count  = fill_count_q;

    assign accept    = in_valid & in_ready;
    assign count_inc = fill_count_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        fill_count_d  = fill_count_q;
        lb_enable_d   = 1'b0;
        lb_shift_in_d = lb_shift_in_q;
        if (abort) begin
            state_d      = S_IDLE;
            fill_count_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d      = S_FILL;
                        fill_count_d = '0;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        lb_enable_d   = 1'b1;
                        lb_shift_in_d = in_data;
                        fill_count_d  = count_inc;
                        if (count_inc == kDepth) begin
                            state_d = S_SETTLE;
                        end else if (in_last) begin
                            state_d = S_PAD;
                        end
                    end
                end
                // Short line: flush remaining taps with zeros
                S_PAD: begin
                    lb_enable_d   = 1'b1;
                    lb_shift_in_d = '0;
                    fill_count_d  = count_inc;
                    if (count_inc == kDepth) begin
                        state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (line_ack) begin
                        state_d      = S_FILL;
                        fill_count_d = '0;
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    fill_count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            fill_count_q  <= '0;
            lb_enable_q   <= 1'b0;
            lb_shift_in_q <= '0;
        end else begin
            state_q       <= state_d;
            fill_count_q  <= fill_count_d;
            lb_enable_q   <= lb_enable_d;
            lb_shift_in_q <= lb_shift_in_d;
        end
    end

endmodule

// File: doc/line_buffer_feeder.md
LINE_BUFFER_FEEDER -- requirements
Module: line_buffer_feeder

Interface
REQ-001 The block SHALL have parameter pNoTaps, default `kNoOfPartitions, number of line-buffer taps driven.
REQ-002 The block SHALL have parameter pTapsWidth, default `kPartitionSize, shift-register depth between adjacent taps.
REQ-003 The block SHALL have parameter pDataLength, default `kFilteredDataLength, sample width.
REQ-004 The block SHALL have parameter pCountWidth, default 16, width of the fill counter.
REQ-005 The block SHALL define the fill depth D = (pNoTaps-1)*pTapsWidth + 1, the number of shifts needed to fill every tap.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-008 start  input  1  one-cycle request to begin filling a line.
REQ-009 abort  input  1  discard the current line and return to idle.
REQ-010 in_valid  input  1  upstream sample valid.
REQ-011 in_ready  output  1  feeder accepts a sample this cycle.
REQ-012 in_data  input  pDataLength  filtered sample.
REQ-013 in_last  input  1  qualifies in_data as the final sample of the line.
REQ-014 lb_enable  output  1  shift enable to the line buffer.
REQ-015 lb_shift_in  output  pDataLength  sample presented to the line buffer.
REQ-016 line_valid  output  1  all pNoTaps taps hold the current line.
REQ-017 line_ack  input  1  consumer has finished with the held line.
REQ-018 fill_count  output  pCountWidth  number of shifts issued for the current line.

Function
REQ-019 The block SHALL implement the states IDLE, FILL, PAD, SETTLE and HOLD.
REQ-020 In IDLE, start SHALL move the state to FILL and clear fill_count to 0.
REQ-021 in_ready SHALL equal 1 only while the state is FILL.
REQ-022 An accept SHALL occur when in_valid and in_ready are both 1 in cycle t.
- Cycle t+1: lb_enable=1 and lb_shift_in=in_data(t).
- fill_count increments by 1 at the end of cycle t.
REQ-023 lb_enable SHALL be 0 in every cycle that does not follow an accept or fall in PAD, and lb_shift_in SHALL hold its last value when lb_enable=0.
REQ-024 When the accept in cycle t brings fill_count to D, the state SHALL be SETTLE in cycle t+1 and HOLD from cycle t+2.
- This applies whether in_last is 0 or 1.
REQ-025 When in_last is accepted with the new fill_count less than D:
- The state SHALL be PAD from cycle t+1.
- PAD issues lb_enable=1 with lb_shift_in=0 in each cycle, incrementing fill_count.
- When fill_count reaches D, the state SHALL pass to SETTLE, then HOLD.
REQ-026 line_valid SHALL be 1 exactly while the state is HOLD, so it first rises the cycle after the final lb_enable pulse.
REQ-027 In HOLD, in_ready=0 and lb_enable=0, and line_ack SHALL move the state to FILL with fill_count cleared to 0 in the next cycle.
REQ-028 start SHALL be ignored outside IDLE, and line_ack SHALL be ignored outside HOLD.
REQ-029 abort SHALL force the state to IDLE in the next cycle from any state.
- In that next cycle: line_valid=0, lb_enable=0, fill_count=0.
- An accept in the same cycle as abort SHALL NOT generate a shift.
REQ-030 abort SHALL take priority over a simultaneous start, line_ack or accept.
REQ-031 If in_valid=0 during FILL, the state and fill_count SHALL hold, with no timeout.
REQ-032 All outputs except in_ready and line_valid SHALL be registered; in_ready and line_valid SHALL be decoded from the state register only.

Reset
REQ-033 When reset_n=0 at a clock edge, the next cycle SHALL have:
- state=IDLE, in_ready=0, lb_enable=0, lb_shift_in=0, line_valid=0, fill_count=0.
REQ-034 Reset asserted mid-line SHALL discard that line with no further lb_enable pulses, and SHALL take priority over every other input.

Verification (pNoTaps=4, pTapsWidth=3, pDataLength=8, D=10)
REQ-035 Full fill: start, then 10 back-to-back accepts of 1..10 -> lb_enable high for 10 consecutive cycles carrying 1..10, SETTLE, line_valid=1 on the 12th cycle after the first accept, fill_count=10.
REQ-036 Early last: 6 samples with in_last on the 6th -> 4 zero-valued PAD shifts, fill_count=10, then line_valid=1.
REQ-037 Stalls: in_valid toggling 1/0 during fill -> lb_enable pulses only after accepts, fill_count frozen while in_valid=0, data order preserved.
REQ-038 Hold/ack: in HOLD with in_valid=1 -> in_ready stays 0; line_ack -> FILL next cycle, fill_count=0, next line refills correctly.
REQ-039 Abort: abort asserted together with the 5th accept -> no 5th shift, IDLE next cycle, fill_count=0; a following start refills from 0.
REQ-040 Reset: reset_n=0 during PAD -> all outputs at reset values next cycle, no further lb_enable pulses.
